// File: rtl/lms_sample_feeder_if.sv
// rtl/lms_sample_feeder_if.sv - sample-pair stream (x, d) from the ADC front end into the feeder
interface lms_sample_feeder_if #(
   parameter int X_W = 16,
   parameter int D_W = 16
);
   logic           s_valid;
   logic           s_ready;
   logic [X_W-1:0] s_x;
   logic [D_W-1:0] s_d;

   modport master (output s_valid, output s_x, output s_d, input s_ready);
   modport slave  (input s_valid, input s_x, input s_d, output s_ready);
endinterface

// File: rtl/lms_sample_feeder.sv
// rtl/lms_sample_feeder.sv - sample-pair FIFO and issue FSM feeding the 16-tap LMS core
// Optional step-size annealing is enabled with `define STEP_ANNEAL_EN.
module lms_sample_feeder #(
   parameter int X_W      = 16,
   parameter int D_W      = 16,
   parameter int DEPTH    = 8,
   parameter int TMO_CYC  = 64,
   parameter int CNT_W    = 32,
   parameter int ANNEAL_N = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 run,
   lms_sample_feeder_if.slave   s,
   input  logic [7:0]           u_cfg,
   output logic                 lms_en,
   output logic [X_W-1:0]       lms_x,
   output logic [D_W-1:0]       lms_d,
   output logic [7:0]           lms_u,
   input  logic                 lms_update,
   output logic                 busy,
   output logic                 tmo_err,
   output logic                 ovf_err,
   output logic [CNT_W-1:0]     done_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
   // The counter is cleared in ISSUE, so hitting TMO_CYC-2 in WAIT makes tmo_err
   // visible exactly TMO_CYC cycles after the lms_en strobe.
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 2);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t         state, state_nx;
   logic [X_W-1:0] x_mem [DEPTH];
   logic [D_W-1:0] d_mem [DEPTH];
   logic [AW:0]    wr_ptr, rd_ptr;
   logic [TW-1:0]  tmo_cnt;
   logic           empty, full, wr_en, pop;
   logic           done_inc, tmo_hit;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign s.s_ready = !full;
   assign wr_en     = s.s_valid && !full && !clr;
   assign pop       = (state == IDLE) && run && !empty && !clr;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         x_mem[wr_ptr[AW-1:0]] <= s.s_x;
         d_mem[wr_ptr[AW-1:0]] <= s.s_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      lms_en   = 1'b0;
      done_inc = 1'b0;
      tmo_hit  = 1'b0;
      case (state)
         IDLE: begin
            if (pop) state_nx = ISSUE;
         end
         ISSUE: begin
            lms_en   = 1'b1;
            state_nx = WAIT;
         end
         WAIT: begin
            if (lms_update) begin
               done_inc = 1'b1;
               state_nx = IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (clr) begin
         state_nx = IDLE;
         lms_en   = 1'b0;
         done_inc = 1'b0;
         tmo_hit  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         lms_x    <= '0;
         lms_d    <= '0;
         tmo_cnt  <= '0;
         tmo_err  <= 1'b0;
         ovf_err  <= 1'b0;
         done_cnt <= '0;
      end else if (clr) begin
         // lms_x/lms_d deliberately keep their last values across a flush
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tmo_cnt  <= '0;
         tmo_err  <= 1'b0;
         ovf_err  <= 1'b0;
         done_cnt <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
            lms_x  <= x_mem[rd_ptr[AW-1:0]];
            lms_d  <= d_mem[rd_ptr[AW-1:0]];
         end
         if (s.s_valid && full) ovf_err <= 1'b1;
         if (tmo_hit) tmo_err <= 1'b1;
         if (done_inc) done_cnt <= done_cnt + CNT_W'(1);
         if (state == ISSUE) begin
            tmo_cnt <= '0;
         end else if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
      end
   end

`ifdef STEP_ANNEAL_EN
   localparam int NW = (ANNEAL_N > 1) ? $clog2(ANNEAL_N) : 1;
   logic [NW-1:0] ann_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lms_u   <= 8'd0;
         ann_cnt <= '0;
      end else if (clr) begin
         lms_u   <= 8'd0;
         ann_cnt <= '0;
      end else if (done_inc) begin
         if (ann_cnt == NW'(ANNEAL_N - 1)) begin
            ann_cnt <= '0;
            if (lms_u < u_cfg) lms_u <= lms_u + 8'd1;
         end else begin
            ann_cnt <= ann_cnt + NW'(1);
         end
      end else if (state == IDLE && u_cfg < lms_u) begin
         lms_u <= u_cfg;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lms_u <= 8'd0;
      end else if (state == IDLE) begin
         lms_u <= u_cfg;
      end
   end
`endif

endmodule

// File: tb/tb_lms_sample_feeder.sv
// tb/tb_lms_sample_feeder.sv - directed bench for lms_sample_feeder with a simple LMS responder
module tb_lms_sample_feeder;
   localparam int X_W = 16, D_W = 16, DEPTH = 8, TMO_CYC = 16, CNT_W = 4, ANNEAL_N = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr = 1'b0;
   logic             run = 1'b0;
   logic [7:0]       u_cfg = 8'd0;
   logic             lms_en;
   logic [X_W-1:0]   lms_x;
   logic [D_W-1:0]   lms_d;
   logic [7:0]       lms_u;
   logic             lms_update = 1'b0;
   logic             busy, tmo_err, ovf_err;
   logic [CNT_W-1:0] done_cnt;

   int total = 0;
   int bad = 0;
   bit upd_on = 1'b0;
   int upd_lat = 5;
   int upd_cnt = 0;

   lms_sample_feeder_if #(.X_W(X_W), .D_W(D_W)) sif ();

   lms_sample_feeder #(
      .X_W(X_W), .D_W(D_W), .DEPTH(DEPTH), .TMO_CYC(TMO_CYC), .CNT_W(CNT_W), .ANNEAL_N(ANNEAL_N)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .run(run), .s(sif), .u_cfg(u_cfg),
      .lms_en(lms_en), .lms_x(lms_x), .lms_d(lms_d), .lms_u(lms_u), .lms_update(lms_update),
      .busy(busy), .tmo_err(tmo_err), .ovf_err(ovf_err), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   // LMS core stand-in: pulses lms_update upd_lat cycles after each lms_en
   initial begin
      forever begin
         @(posedge clk);
         #1;
         lms_update = 1'b0;
         if (upd_on && lms_en) begin
            upd_cnt = upd_lat;
         end else if (upd_cnt > 0) begin
            upd_cnt--;
            if (upd_cnt == 0) lms_update = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic push(input logic [15:0] x, input logic [15:0] d);
      sif.s_valid = 1'b1;
      sif.s_x = x;
      sif.s_d = d;
      tick();
      sif.s_valid = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      total++; if (sif.s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%0b want=1", sif.s_ready); end
      total++; if ({lms_en, busy, tmo_err, ovf_err} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {lms_en, busy, tmo_err, ovf_err}); end
      total++; if ({lms_x, lms_d, lms_u, done_cnt} !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", {lms_x, lms_d, lms_u, done_cnt}); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      upd_on = 1'b1; upd_lat = 5; run = 1'b1;
      push(16'h0100, 16'hFF00);
      total++; if (lms_en !== 1'b0) begin bad++; $display("FAIL single_en_t1 got=%0b want=0", lms_en); end
      tick();
      total++; if (lms_en !== 1'b1) begin bad++; $display("FAIL single_en_t2 got=%0b want=1", lms_en); end
      total++; if (lms_x !== 16'h0100 || lms_d !== 16'hFF00) begin bad++; $display("FAIL single_xd got=%h/%h want=0100/ff00", lms_x, lms_d); end
      tick();
      total++; if (lms_en !== 1'b0) begin bad++; $display("FAIL single_en_pulse got=%0b want=0", lms_en); end
      repeat (4) tick();
      total++; if (lms_x !== 16'h0100 || lms_d !== 16'hFF00 || done_cnt !== 4'd0 || lms_update !== 1'b1) begin
         bad++; $display("FAIL single_hold got=%h/%h cnt=%0d upd=%0b want=0100/ff00 cnt=0 upd=1", lms_x, lms_d, done_cnt, lms_update);
      end
      tick();
      total++; if (done_cnt !== 4'd1 || busy !== 1'b0) begin bad++; $display("FAIL single_done got=cnt%0d busy%0b want=cnt1 busy0", done_cnt, busy); end
   endtask

   task automatic test_burst();
      int n = 0;
      bit order_ok = 1'b1;
      do_clr();
      run = 1'b0; upd_on = 1'b1; upd_lat = 2;
      for (int i = 0; i < 10; i++) begin
         total++; if (sif.s_ready !== (i < 8)) begin bad++; $display("FAIL burst_ready[%0d] got=%0b want=%0b", i, sif.s_ready, (i < 8)); end
         sif.s_valid = 1'b1; sif.s_x = 16'h0010 + 16'(i); sif.s_d = 16'h0020 + 16'(i);
         tick();
      end
      sif.s_valid = 1'b0;
      total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL burst_ovf got=%0b want=1", ovf_err); end
      run = 1'b1;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (lms_en) begin
            if (lms_x !== 16'h0010 + 16'(n) || lms_d !== 16'h0020 + 16'(n)) order_ok = 1'b0;
            n++;
         end
         if (n == 8 && !busy) break;
      end
      total++; if (n !== 8 || !order_ok) begin bad++; $display("FAIL burst_issues got=%0d ordered=%0b want=8 ordered=1", n, order_ok); end
      total++; if (done_cnt !== 4'd8 || sif.s_ready !== 1'b1) begin bad++; $display("FAIL burst_done got=%0d ready=%0b want=8 ready=1", done_cnt, sif.s_ready); end
   endtask

   task automatic test_timeout();
      bit early = 1'b0;
      do_clr();
      upd_on = 1'b0; run = 1'b1;
      push(16'h0A0A, 16'h1111);
      push(16'h0B0B, 16'h2222);
      total++; if (lms_en !== 1'b1 || lms_x !== 16'h0A0A) begin bad++; $display("FAIL tmo_issue_a got=%0b/%h want=1/0a0a", lms_en, lms_x); end
      for (int k = 1; k < TMO_CYC; k++) begin
         tick();
         early |= tmo_err;
      end
      total++; if (early !== 1'b0) begin bad++; $display("FAIL tmo_early got=1 want=0"); end
      tick();
      total++; if (tmo_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL tmo_set got=%0b busy=%0b want=1 busy0", tmo_err, busy); end
      tick();
      total++; if (lms_en !== 1'b1 || lms_x !== 16'h0B0B || lms_d !== 16'h2222) begin bad++; $display("FAIL tmo_resume got=%0b/%h/%h want=1/0b0b/2222", lms_en, lms_x, lms_d); end
   endtask

   task automatic test_clr();
      bit en_seen = 1'b0;
      push(16'h0C01, 16'h3001);
      push(16'h0C02, 16'h3002);
      push(16'h0C03, 16'h3003);
      clr = 1'b1;
      sif.s_valid = 1'b1; sif.s_x = 16'h0DDD; sif.s_d = 16'h4DDD;
      total++; if (lms_en !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL clr_pre got=en%0b busy%0b want=en0 busy1", lms_en, busy); end
      tick();
      clr = 1'b0; sif.s_valid = 1'b0;
      total++; if (sif.s_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL clr_state got=ready%0b busy%0b want=ready1 busy0", sif.s_ready, busy); end
      total++; if (tmo_err !== 1'b0 || ovf_err !== 1'b0 || done_cnt !== 4'd0) begin bad++; $display("FAIL clr_flags got=%0b%0b cnt%0d want=00 cnt0", tmo_err, ovf_err, done_cnt); end
      total++; if (lms_x !== 16'h0B0B || lms_d !== 16'h2222) begin bad++; $display("FAIL clr_hold got=%h/%h want=0b0b/2222", lms_x, lms_d); end
      for (int k = 0; k < 5; k++) begin
         en_seen |= lms_en;
         tick();
      end
      total++; if (en_seen !== 1'b0) begin bad++; $display("FAIL clr_no_en got=1 want=0"); end
   endtask

   task automatic test_run_pause();
      bit en_seen = 1'b0;
      do_clr();
      upd_on = 1'b1; upd_lat = 5; run = 1'b1;
      push(16'h0E01, 16'h5001);
      push(16'h0E02, 16'h5002);
      tick();
      run = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         en_seen |= lms_en;
      end
      total++; if (en_seen !== 1'b0 || done_cnt !== 4'd1 || busy !== 1'b0) begin
         bad++; $display("FAIL pause_hold got=en%0b cnt%0d busy%0b want=en0 cnt1 busy0", en_seen, done_cnt, busy);
      end
      run = 1'b1;
      tick();
      total++; if (lms_en !== 1'b1 || lms_x !== 16'h0E02) begin bad++; $display("FAIL pause_resume got=%0b/%h want=1/0e02", lms_en, lms_x); end
      repeat (6) tick();
      total++; if (done_cnt !== 4'd2) begin bad++; $display("FAIL pause_done got=%0d want=2", done_cnt); end
   endtask

`ifdef STEP_ANNEAL_EN
   task automatic test_step();
      logic [7:0] exp_u [3];
      exp_u[0] = 8'd1; exp_u[1] = 8'd2; exp_u[2] = 8'd2;
      do_clr();
      total++; if (lms_u !== 8'd0) begin bad++; $display("FAIL anneal_start got=%0d want=0", lms_u); end
      u_cfg = 8'd2; upd_on = 1'b1; upd_lat = 1; run = 1'b1;
      for (int g = 0; g < 3; g++) begin
         for (int j = 0; j < 4; j++) begin
            push(16'h0F00 + 16'(j), 16'h6000);
            repeat (3) tick();
         end
         total++; if (lms_u !== exp_u[g]) begin bad++; $display("FAIL anneal_step[%0d] got=%0d want=%0d", g, lms_u, exp_u[g]); end
      end
      u_cfg = 8'd1;
      tick();
      total++; if (lms_u !== 8'd1) begin bad++; $display("FAIL anneal_ceiling got=%0d want=1", lms_u); end
   endtask
`else
   task automatic test_step();
      u_cfg = 8'd5; upd_on = 1'b1; upd_lat = 5; run = 1'b1;
      repeat (2) tick();
      total++; if (lms_u !== 8'd5) begin bad++; $display("FAIL step_idle got=%0d want=5", lms_u); end
      push(16'h0F0F, 16'h7070);
      tick();
      u_cfg = 8'd7;
      tick();
      total++; if (lms_u !== 8'd5) begin bad++; $display("FAIL step_hold got=%0d want=5", lms_u); end
      for (int k = 0; k < 20 && busy; k++) tick();
      tick();
      total++; if (lms_u !== 8'd7) begin bad++; $display("FAIL step_update got=%0d want=7", lms_u); end
   endtask
`endif

   task automatic test_wrap();
      do_clr();
      upd_on = 1'b1; upd_lat = 1; run = 1'b1;
      for (int i = 0; i < 17; i++) begin
         push(16'(i), 16'(i));
         repeat (3) tick();
         if (i == 14) begin
            total++; if (done_cnt !== 4'd15) begin bad++; $display("FAIL wrap_max got=%0d want=15", done_cnt); end
         end else if (i == 15) begin
            total++; if (done_cnt !== 4'd0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", done_cnt); end
         end
      end
      total++; if (done_cnt !== 4'd1) begin bad++; $display("FAIL wrap_after got=%0d want=1", done_cnt); end
   endtask

   task automatic test_async_reset();
      bit en_seen = 1'b0;
      upd_on = 1'b1; upd_lat = 5; run = 1'b1;
      push(16'h0ABC, 16'h0DEF);
      tick();
      tick();
      #1 rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || lms_en !== 1'b0 || sif.s_ready !== 1'b1) begin bad++; $display("FAIL arst_ctrl got=busy%0b en%0b ready%0b want=0 0 1", busy, lms_en, sif.s_ready); end
      total++; if (lms_x !== 16'h0 || lms_d !== 16'h0 || lms_u !== 8'd0 || done_cnt !== 4'd0) begin
         bad++; $display("FAIL arst_data got=%h/%h u%0d cnt%0d want=0", lms_x, lms_d, lms_u, done_cnt);
      end
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         en_seen |= lms_en;
      end
      total++; if (en_seen !== 1'b0 || done_cnt !== 4'd0) begin bad++; $display("FAIL arst_after got=en%0b cnt%0d want=en0 cnt0", en_seen, done_cnt); end
   endtask

   initial begin
      sif.s_valid = 1'b0;
      sif.s_x = '0;
      sif.s_d = '0;
      test_reset();
      test_single();
      test_burst();
      test_timeout();
      test_clr();
      test_run_pause();
      test_step();
      test_wrap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
